// File: rtl/eeprom_rw_test.sv
// EEPROM write/read-back self-test sequencer; drives one IIC byte transaction at a time
// and reports pass/fail with the first mismatching address.
module eeprom_rw_test #(
  parameter logic [6:0]  SLAVE_ADDR = 7'b1010000,
  parameter logic        ADDR16     = 1'b1,
  parameter logic [15:0] START_ADDR = 16'd0,
  parameter logic [15:0] BYTE_NUM   = 16'd256,
  parameter logic [7:0]  SEED       = 8'hA5,
  parameter int unsigned TWR_CYCLES = 250_000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        start,
  output logic        iic_en,
  output logic [6:0]  iic_slave_addr,
  output logic [15:0] iic_dev_addr,
  output logic        iic_bit_sel,
  output logic        iic_rh_wl,
  output logic [7:0]  iic_write_data,
  input  logic [7:0]  iic_read_data,
  input  logic        iic_done,
  output logic        busy,
  output logic        pass,
  output logic        fail,
  output logic [15:0] err_addr,
  output logic        led
);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_WAIT, WR_GAP, RD_REQ, RD_WAIT, CHECK, FINISH
  } state_t;

  localparam logic [15:0] LAST_IDX = BYTE_NUM - 16'd1;
  localparam logic [31:0] GAP_LAST = (TWR_CYCLES == 0) ? 32'd0 : 32'(TWR_CYCLES - 1);

  state_t      state, state_d;
  logic [15:0] addr, addr_d;
  logic [15:0] idx, idx_d;
  logic [31:0] gap_cnt, gap_d;
  logic [7:0]  rd_q, rd_d;
  logic        en_d, rh_d, busy_d, pass_d, fail_d;
  logic [15:0] dev_d, err_d;
  logic [7:0]  wd_d;
  logic [7:0]  exp_byte;

  logic        done_meta, done_sync, done_last;
  logic        done_p;
  logic [22:0] blink_cnt;

  assign iic_slave_addr = SLAVE_ADDR;
  assign iic_bit_sel    = ADDR16;

  // iic_done comes from the Scl4x domain; only a fresh rising edge counts as completion
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      done_meta <= 1'b0;
      done_sync <= 1'b0;
      done_last <= 1'b0;
    end else begin
      done_meta <= iic_done;
      done_sync <= done_meta;
      done_last <= done_sync;
    end
  end

  assign done_p = done_sync & ~done_last;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state          <= IDLE;
      addr           <= START_ADDR;
      idx            <= '0;
      gap_cnt        <= '0;
      rd_q           <= '0;
      iic_en         <= 1'b0;
      iic_rh_wl      <= 1'b0;
      iic_dev_addr   <= START_ADDR;
      iic_write_data <= '0;
      busy           <= 1'b0;
      pass           <= 1'b0;
      fail           <= 1'b0;
      err_addr       <= '0;
    end else begin
      state          <= state_d;
      addr           <= addr_d;
      idx            <= idx_d;
      gap_cnt        <= gap_d;
      rd_q           <= rd_d;
      iic_en         <= en_d;
      iic_rh_wl      <= rh_d;
      iic_dev_addr   <= dev_d;
      iic_write_data <= wd_d;
      busy           <= busy_d;
      pass           <= pass_d;
      fail           <= fail_d;
      err_addr       <= err_d;
    end
  end

  always_comb begin
    state_d  = state;
    addr_d   = addr;
    idx_d    = idx;
    gap_d    = gap_cnt;
    rd_d     = rd_q;
    en_d     = iic_en;
    rh_d     = iic_rh_wl;
    dev_d    = iic_dev_addr;
    wd_d     = iic_write_data;
    busy_d   = busy;
    pass_d   = pass;
    fail_d   = fail;
    err_d    = err_addr;
    exp_byte = addr[7:0] ^ SEED;

    unique case (state)
      IDLE: begin
        if (start) begin
          addr_d  = START_ADDR;
          idx_d   = '0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        rh_d    = 1'b0;
        dev_d   = addr;
        wd_d    = exp_byte;
        en_d    = 1'b1;
        state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (done_p) begin
          en_d    = 1'b0;
          gap_d   = '0;
          state_d = WR_GAP;
        end
      end
      WR_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          gap_d = '0;
          if (idx == LAST_IDX) begin
            idx_d   = '0;
            addr_d  = START_ADDR;
            state_d = RD_REQ;
          end else begin
            idx_d   = idx + 16'd1;
            addr_d  = addr + 16'd1;
            state_d = WR_REQ;
          end
        end else begin
          gap_d = gap_cnt + 32'd1;
        end
      end
      RD_REQ: begin
        rh_d    = 1'b1;
        dev_d   = addr;
        en_d    = 1'b1;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (done_p) begin
          rd_d    = iic_read_data;
          en_d    = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        // busy drops on entry to FINISH so it falls together with pass/fail
        if (rd_q != exp_byte) begin
          fail_d  = 1'b1;
          err_d   = addr;
          busy_d  = 1'b0;
          state_d = FINISH;
        end else if (idx == LAST_IDX) begin
          pass_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = FINISH;
        end else begin
          idx_d   = idx + 16'd1;
          addr_d  = addr + 16'd1;
          state_d = RD_REQ;
        end
      end
      FINISH: begin
        busy_d = 1'b0;
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status LED: slow blink while running, solid on pass, fast blink on fail
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      blink_cnt <= '0;
      led       <= 1'b0;
    end else if (pass) begin
      blink_cnt <= '0;
      led       <= 1'b1;
    end else if (busy) begin
      blink_cnt <= blink_cnt + 23'd1;
      if (&blink_cnt) led <= ~led;
    end else if (fail) begin
      blink_cnt <= blink_cnt + 23'd1;
      if (&blink_cnt[20:0]) led <= ~led;
    end else begin
      blink_cnt <= '0;
      led       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_eeprom_rw_test.sv
// Directed bench for eeprom_rw_test: behavioural IIC driver models with request scoreboards.
`timescale 1ns/1ps
module tb_eeprom_rw_test;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst_n[2], start[2], en[2], rh[2], done[2], busy[2];
  logic        pass_o[2], fail_o[2], led_o[2], bs[2];
  logic [6:0]  sa[2];
  logic [15:0] dev[2], err[2];
  logic [7:0]  wd[2], rd[2];

  int          n_cmp = 0;
  int          n_err = 0;
  int          hold_cyc = 6;
  logic        corrupt = 1'b0;
  logic [15:0] corrupt_addr = 16'h0012;
  int          rises[2];
  int          dp_cnt = 0;

  logic [24:0] tbl_a[8] = '{
    {1'b0, 16'h0010, 8'hB5}, {1'b0, 16'h0011, 8'hB4},
    {1'b0, 16'h0012, 8'hB7}, {1'b0, 16'h0013, 8'hB6},
    {1'b1, 16'h0010, 8'h00}, {1'b1, 16'h0011, 8'h00},
    {1'b1, 16'h0012, 8'h00}, {1'b1, 16'h0013, 8'h00}};
  logic [24:0] tbl_w[4] = '{
    {1'b0, 16'hFFFF, 8'h5A}, {1'b0, 16'h0000, 8'hA5},
    {1'b1, 16'hFFFF, 8'h00}, {1'b1, 16'h0000, 8'h00}};

  eeprom_rw_test #(
    .SLAVE_ADDR(7'b1010000), .ADDR16(1'b1), .START_ADDR(16'h0010),
    .BYTE_NUM(16'd4), .SEED(8'hA5), .TWR_CYCLES(10)
  ) u_dut (
    .Clk(clk), .Rst_n(rst_n[0]), .start(start[0]), .iic_en(en[0]),
    .iic_slave_addr(sa[0]), .iic_dev_addr(dev[0]), .iic_bit_sel(bs[0]),
    .iic_rh_wl(rh[0]), .iic_write_data(wd[0]), .iic_read_data(rd[0]),
    .iic_done(done[0]), .busy(busy[0]), .pass(pass_o[0]), .fail(fail_o[0]),
    .err_addr(err[0]), .led(led_o[0])
  );

  eeprom_rw_test #(
    .SLAVE_ADDR(7'b1010000), .ADDR16(1'b1), .START_ADDR(16'hFFFF),
    .BYTE_NUM(16'd2), .SEED(8'hA5), .TWR_CYCLES(10)
  ) u_wrap (
    .Clk(clk), .Rst_n(rst_n[1]), .start(start[1]), .iic_en(en[1]),
    .iic_slave_addr(sa[1]), .iic_dev_addr(dev[1]), .iic_bit_sel(bs[1]),
    .iic_rh_wl(rh[1]), .iic_write_data(wd[1]), .iic_read_data(rd[1]),
    .iic_done(done[1]), .busy(busy[1]), .pass(pass_o[1]), .fail(fail_o[1]),
    .err_addr(err[1]), .led(led_o[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver model: each request is scored against the queue, then answered with a done pulse
  for (genvar g = 0; g < 2; g++) begin : g_mdl
    logic [24:0] exp_q[$];
    logic [7:0]  mem[256];
    logic        active = 1'b0;
    initial begin
      logic [24:0] obs;
      done[g] = 1'b0;
      rd[g]   = '0;
      forever begin
        @(negedge clk);
        if (en[g] === 1'b1) begin
          active = 1'b1;
          obs = {rh[g], dev[g], (rh[g] ? 8'h00 : wd[g])};
          check("req_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) check("req_cmd", obs, exp_q.pop_front());
          if (rh[g]) rd[g] = (g == 0 && corrupt && dev[g] == corrupt_addr) ? 8'h00 : mem[dev[g][7:0]];
          else mem[dev[g][7:0]] = wd[g];
          repeat (3) @(negedge clk);
          done[g] = 1'b1;
          repeat (hold_cyc) @(negedge clk);
          done[g] = 1'b0;
          active = 1'b0;
        end
      end
    end
  end

  initial begin
    logic p0, p1;
    p0 = 1'b0;
    p1 = 1'b0;
    forever begin
      @(negedge clk);
      if (en[0] === 1'b1 && !p0) rises[0]++;
      if (en[1] === 1'b1 && !p1) rises[1]++;
      if (u_dut.done_p === 1'b1) dp_cnt++;
      p0 = (en[0] === 1'b1);
      p1 = (en[1] === 1'b1);
    end
  end

  task automatic push_exp(input int g, input logic [24:0] v);
    if (g == 0) g_mdl[0].exp_q.push_back(v);
    else g_mdl[1].exp_q.push_back(v);
  endtask

  function automatic int q_size(input int g);
    return (g == 0) ? g_mdl[0].exp_q.size() : g_mdl[1].exp_q.size();
  endfunction

  task automatic push_a(input int n);
    for (int i = 0; i < n; i++) push_exp(0, tbl_a[i]);
  endtask

  task automatic pulse_start(input int g);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g, input string tag);
    int k = 0;
    while (busy[g] !== 1'b0 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_timeout"}, k < 5000, 1);
  endtask

  task automatic wait_model(input int g);
    int k = 0;
    while (((g == 0) ? g_mdl[0].active : g_mdl[1].active) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("model_idle_timeout", k < 500, 1);
  endtask

  initial begin
    int k;
    rises[0] = 0;
    rises[1] = 0;
    rst_n[0] = 1'b0; rst_n[1] = 1'b0;
    start[0] = 1'b0; start[1] = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_en", en[0], 0);
    check("rst_rh", rh[0], 0);
    check("rst_dev", dev[0], 16'h0010);
    check("rst_wd", wd[0], 0);
    check("rst_busy", busy[0], 0);
    check("rst_pass", pass_o[0], 0);
    check("rst_fail", fail_o[0], 0);
    check("rst_err", err[0], 0);
    check("rst_led", led_o[0], 0);
    check("rst_dev_wrap", dev[1], 16'hFFFF);
    check("slave_addr", sa[0], 7'b1010000);
    check("bit_sel", bs[0], 1);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    repeat (2) @(negedge clk);

    // Normal run
    push_a(8);
    rises[0] = 0;
    pulse_start(0);
    check("a_busy_rise", busy[0], 1);
    wait_idle(0, "a");
    check("a_pass_at_busy_fall", pass_o[0], 1);
    check("a_fail", fail_o[0], 0);
    check("a_err", err[0], 0);
    check("a_en_rises", rises[0], 8);
    check("a_queue_empty", q_size(0), 0);
    repeat (2) @(negedge clk);
    check("a_led_pass", led_o[0], 1);
    wait_model(0);

    // Corrupt read at 0x0012
    corrupt = 1'b1;
    push_a(7);
    rises[0] = 0;
    pulse_start(0);
    wait_idle(0, "b");
    repeat (20) @(negedge clk);
    check("b_fail", fail_o[0], 1);
    check("b_pass", pass_o[0], 0);
    check("b_err_addr", err[0], 16'h0012);
    check("b_en_rises", rises[0], 7);
    check("b_queue_empty", q_size(0), 0);
    wait_model(0);
    corrupt = 1'b0;

    // Long iic_done level
    hold_cyc = 60;
    dp_cnt = 0;
    rises[0] = 0;
    push_a(8);
    pulse_start(0);
    wait_idle(0, "c");
    wait_model(0);
    check("c_pass", pass_o[0], 1);
    check("c_done_p_count", dp_cnt, 8);
    check("c_en_rises", rises[0], 8);
    check("c_queue_empty", q_size(0), 0);
    hold_cyc = 6;

    // Reset during the second write wait
    rises[0] = 0;
    push_a(8);
    pulse_start(0);
    k = 0;
    while (rises[0] < 2 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("d_wait2_timeout", k < 2000, 1);
    @(negedge clk);
    check("d_pre_en", en[0], 1);
    check("d_pre_dev", dev[0], 16'h0011);
    rst_n[0] = 1'b0;
    #1;
    check("d_rst_en", en[0], 0);
    check("d_rst_busy", busy[0], 0);
    check("d_rst_addr", u_dut.addr, 16'h0010);
    check("d_rst_dev", dev[0], 16'h0010);
    check("d_rst_led", led_o[0], 0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    wait_model(0);
    g_mdl[0].exp_q.delete();
    rises[0] = 0;
    push_a(8);
    pulse_start(0);
    wait_idle(0, "d_rerun");
    check("d_rerun_pass", pass_o[0], 1);
    check("d_rerun_rises", rises[0], 8);
    check("d_rerun_queue", q_size(0), 0);
    wait_model(0);

    // Address wrap on the second instance
    for (int i = 0; i < 4; i++) push_exp(1, tbl_w[i]);
    pulse_start(1);
    wait_idle(1, "e");
    check("e_pass", pass_o[1], 1);
    check("e_fail", fail_o[1], 0);
    check("e_rises", rises[1], 4);
    check("e_queue_empty", q_size(1), 0);

    // start held high through a whole run
    rises[0] = 0;
    push_a(8);
    start[0] = 1'b1;
    @(negedge clk);
    wait_idle(0, "f");
    check("f_pass", pass_o[0], 1);
    repeat (60) @(negedge clk);
    check("f_no_restart_busy", busy[0], 0);
    check("f_no_restart_rises", rises[0], 8);
    wait_model(0);
    start[0] = 1'b0;
    repeat (2) @(negedge clk);
    rises[0] = 0;
    push_a(8);
    pulse_start(0);
    check("f_restart_busy", busy[0], 1);
    repeat (20) @(negedge clk);
    pulse_start(0);
    wait_idle(0, "f2");
    repeat (20) @(negedge clk);
    check("f2_pass", pass_o[0], 1);
    check("f2_rises", rises[0], 8);
    check("f2_queue_empty", q_size(0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
